// File: rtl/dram_arb_pkg.sv
// Shared definitions for the two-port data RAM arbiter: FSM state
// encoding, requester port IDs and default bus widths.
package dram_arb_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker. A lone request always wins;
// on a tie the port that did not own the previous transaction wins.
module rr_arb2
    import dram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic grant_valid,
    output logic grant_id
);

    // Pick a winner from the current requests and the last owner.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = PORT_CPU;
        if (req0 && req1) begin
            grant_id = (last == PORT_CPU) ? PORT_DBG : PORT_CPU;
        end else if (req1) begin
            grant_id = PORT_DBG;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Shares the single data RAM port between the CPU (port 0) and the
// debug/loader engine (port 1). Every access is a fixed IDLE -> ACCESS ->
// RESP sequence; ties are broken round-robin.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN and holds all of
// them stable until ackN. ackN is a single-cycle pulse in RESP; rdataN is
// valid only while ackN is high and reads as 0 otherwise. In the cycle after
// ackN the requester either drops reqN or presents its next transaction;
// a req still high in IDLE is taken as a new transaction.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic          busy,
    output logic          owner,
    output arb_state_t    dbg_state
);

    arb_state_t    state;
    logic          last;
    logic          ack_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          grant_valid;
    logic          grant_id;

    rr_arb2 u_rr_arb2 (
        .req0        (req0),
        .req1        (req1),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Transaction sequencer: requester inputs are sampled only in IDLE, and
    // ram_we is a registered pulse that exists only in ACCESS so reset
    // removes it immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            last    <= PORT_DBG;
            owner   <= PORT_CPU;
            addr_q  <= '0;
            wdata_q <= '0;
            ram_we  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q  <= 1'b0;
                    ram_we <= 1'b0;
                    if (grant_valid) begin
                        owner   <= grant_id;
                        addr_q  <= (grant_id == PORT_DBG) ? addr1  : addr0;
                        wdata_q <= (grant_id == PORT_DBG) ? wdata1 : wdata0;
                        ram_we  <= (grant_id == PORT_DBG) ? we1    : we0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    ram_we <= 1'b0;
                    ack_q  <= 1'b1;
                    state  <= RESP;
                end
                RESP: begin
                    ack_q <= 1'b0;
                    last  <= owner;
                    state <= IDLE;
                end
                default: begin
                    ram_we <= 1'b0;
                    ack_q  <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // The RAM output is unregistered, so read data is steered straight from
    // ram_q to the owning port during its ack cycle and forced to 0 elsewhere.
    always_comb begin
        ack0   = ack_q && (owner == PORT_CPU);
        ack1   = ack_q && (owner == PORT_DBG);
        rdata0 = ack0 ? ram_q : '0;
        rdata1 = ack1 ? ram_q : '0;
    end

    assign ram_addr  = addr_q;
    assign ram_data  = wdata_q;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a behavioural RAM model. Drivers push
// the expected read data per port; a monitor pops and compares on every ack.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] ram_addr, ram_data, ram_q;
    logic        ram_we, busy, owner;
    arb_state_t  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int we_cnt  = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic        ack_log[$];
    int          ack_cyc[$];

    // RAM model: registered address/data/we, unregistered output
    logic [15:0] mem [0:65535] = '{default: 16'h0000};
    logic [15:0] ram_addr_r = '0;

    dram_arbiter #(.AW(16), .DW(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we    (ram_we),
        .ram_q     (ram_q),
        .busy      (busy),
        .owner     (owner),
        .dbg_state (dbg_state)
    );

    // clock / cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_addr_r <= ram_addr;
    end
    assign ram_q = mem[ram_addr_r];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clock) begin
        if (ram_we) begin
            we_cnt++;
            check("we_only_in_access", 32'(dbg_state), 32'(ACCESS));
        end
        if (ack0 && ack1) check("ack_overlap", 32'(1), 32'(0));
        if (ack0) begin
            ack_log.push_back(1'b0);
            ack_cyc.push_back(cyc);
            check("owner_on_ack0", 32'(owner), 32'(0));
            check("rdata1_idle_on_ack0", 32'(rdata1), 32'(0));
            if (exp_q0.size() == 0) check("unexpected_ack0", 32'(1), 32'(0));
            else check("rdata0", 32'(rdata0), 32'(exp_q0.pop_front()));
        end
        if (ack1) begin
            ack_log.push_back(1'b1);
            ack_cyc.push_back(cyc);
            check("owner_on_ack1", 32'(owner), 32'(1));
            check("rdata0_idle_on_ack1", 32'(rdata0), 32'(0));
            if (exp_q1.size() == 0) check("unexpected_ack1", 32'(1), 32'(0));
            else check("rdata1", 32'(rdata1), 32'(exp_q1.pop_front()));
        end
    end

    // driver tasks
    task automatic drive(input bit port, input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
        if (port) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
        else      begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    task automatic wait_ack(input bit port, output int lat);
        bit found = 0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (port ? ack1 : ack0) begin found = 1; break; end
            @(posedge clock);
            lat++;
        end
        if (!found) check("ack_timeout", 32'(0), 32'(1));
    endtask

    // Call at posedge+#1; returns at posedge+#1 after the ack cycle
    task automatic access(input bit port, input bit w, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp, output int lat);
        if (port) exp_q1.push_back(exp); else exp_q0.push_back(exp);
        drive(port, 1'b1, w, a, d);
        wait_ack(port, lat);
        @(posedge clock); #1;
        drive(port, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
    endtask

    int lat, lat1, base, we_base, idle_cnt;

    initial begin
        // reset state
        apply_reset();
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_owner", 32'(owner), 32'(0));
        check("rst_ack0", 32'(ack0), 32'(0));
        check("rst_ack1", 32'(ack1), 32'(0));
        check("rst_rdata0", 32'(rdata0), 32'(0));
        check("rst_rdata1", 32'(rdata1), 32'(0));
        check("rst_ram_addr", 32'(ram_addr), 32'(0));
        check("rst_ram_data", 32'(ram_data), 32'(0));
        check("rst_ram_we", 32'(ram_we), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // port 0 write then read back
        we_base = we_cnt;
        access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'hBEEF, lat);
        check("write_latency", 32'(lat), 32'(2));
        check("write_we_cycles", 32'(we_cnt - we_base), 32'(1));
        we_base = we_cnt;
        access(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, lat);
        check("read_latency", 32'(lat), 32'(2));
        check("read_we_cycles", 32'(we_cnt - we_base), 32'(0));

        // simultaneous requests right after reset: port 0 first
        apply_reset();
        base = ack_log.size();
        fork
            access(1'b0, 1'b1, 16'h0100, 16'h1111, 16'h1111, lat);
            access(1'b1, 1'b1, 16'h0200, 16'h2222, 16'h2222, lat1);
        join
        check("tie_acks", 32'(ack_log.size() - base), 32'(2));
        if (ack_log.size() >= base + 2) begin
            check("tie_first", 32'(ack_log[base]), 32'(0));
            check("tie_second", 32'(ack_log[base + 1]), 32'(1));
        end
        check("tie_lat0", 32'(lat), 32'(2));
        check("tie_lat1", 32'(lat1), 32'(5));

        // both held continuously: strict alternation, one idle cycle between acks
        base = ack_log.size();
        idle_cnt = 0;
        fork
            for (int i = 0; i < 3; i++) access(1'b0, 1'b1, 16'h0300 + 16'(i), 16'hA000 + 16'(i), 16'hA000 + 16'(i), lat);
            for (int i = 0; i < 3; i++) access(1'b1, 1'b1, 16'h0400 + 16'(i), 16'hB000 + 16'(i), 16'hB000 + 16'(i), lat1);
            for (int i = 0; i < 100 && ack_log.size() < base + 6; i++) begin
                @(negedge clock); #2;
                if (ack_log.size() > base && ack_log.size() < base + 6 && !busy) idle_cnt++;
            end
        join
        check("burst_acks", 32'(ack_log.size() - base), 32'(6));
        if (ack_log.size() >= base + 6) begin
            for (int k = 0; k < 6; k++) check("burst_order", 32'(ack_log[base + k]), 32'(k % 2));
            for (int k = 0; k < 5; k++) check("burst_gap3", 32'(ack_cyc[base + k + 1] - ack_cyc[base + k]), 32'(3));
            for (int k = 0; k < 4; k++) check("burst_gap6", 32'(ack_cyc[base + k + 2] - ack_cyc[base + k]), 32'(6));
        end
        check("burst_idle_cycles", 32'(idle_cnt), 32'(5));

        // top address, no wrap to 0x0000
        access(1'b1, 1'b1, 16'hFFFF, 16'h1234, 16'h1234, lat);
        access(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h1234, lat);
        access(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, lat);

        // inputs changed while busy are ignored
        exp_q1.push_back(16'h5555);
        drive(1'b1, 1'b1, 1'b1, 16'h0020, 16'h5555);
        @(posedge clock); #1;
        drive(1'b1, 1'b1, 1'b1, 16'h0030, 16'h6666);
        check("busy_in_access", 32'(busy), 32'(1));
        check("held_addr", 32'(ram_addr), 32'(16'h0020));
        check("held_data", 32'(ram_data), 32'(16'h5555));
        wait_ack(1'b1, lat);
        check("held_latency", 32'(lat), 32'(1));
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        access(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h5555, lat);
        access(1'b0, 1'b0, 16'h0030, 16'h0000, 16'h0000, lat);

        // reset during RESP of a port 0 read: abandoned, all outputs clear
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_ack0", 32'(ack0), 32'(0));
        check("mid_rst_rdata0", 32'(rdata0), 32'(0));
        check("mid_rst_ram_addr", 32'(ram_addr), 32'(0));
        check("mid_rst_ram_we", 32'(ram_we), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;
        base = ack_log.size();
        fork
            access(1'b0, 1'b1, 16'h0040, 16'h4444, 16'h4444, lat);
            access(1'b1, 1'b1, 16'h0050, 16'h5151, 16'h5151, lat1);
        join
        if (ack_log.size() >= base + 2) begin
            check("post_rst_first", 32'(ack_log[base]), 32'(0));
            check("post_rst_second", 32'(ack_log[base + 1]), 32'(1));
        end else begin
            check("post_rst_acks", 32'(ack_log.size() - base), 32'(2));
        end

        repeat (3) @(posedge clock);
        check("q0_drained", 32'(exp_q0.size()), 32'(0));
        check("q1_drained", 32'(exp_q1.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port arbiter and sequencer for the 16-bit, 64K-word data RAM (`lpm_ram_dq`, registered address/data-in, unregistered output). It shares the single RAM port between the CPU core (port 0) and a debug/loader engine (port 1). Each access is a fixed three-phase transaction with round-robin fairness. It sits between the requesters and the RAM instance, and is the only driver of the RAM's `address`, `data` and `we`.

## Interface
- `AW`, 16: RAM address width.
- `DW`, 16: RAM data width.

- `clock`  in  1  rising-edge system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  access request; must be held, with its address/data, until the matching ack.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  AW  word address.
- `wdata0`, `wdata1`  in  DW  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  DW  read data; valid only while the matching ack is high.
- `ram_addr`  out  AW  to RAM `address`.
- `ram_data`  out  DW  to RAM `data`.
- `ram_we`  out  1  to RAM `we`.
- `ram_q`  in  DW  from RAM `q`.
- `busy`  out  1  transaction in progress (state != IDLE).
- `owner`  out  1  port that owns the current or most recent transaction.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the port that is not `last`.
  - On grant: latch owner, we, addr and wdata into internal registers; go to ACCESS.
- **ACCESS**
  - `ram_addr` and `ram_data` come from the latched values.
  - `ram_we` = latched we.
  - Go to RESP.
- **RESP**
  - `ram_we` = 0; `ram_addr` still holds the latched address.
  - The owner's ack = 1 and its rdata = `ram_q`. Write transactions also ack, with rdata = `ram_q`, which is the newly written word.
  - Set `last` <= owner; go to IDLE.
- The non-owner's ack is always 0, and its rdata is 0.
- Requester inputs are sampled only in IDLE. Changes to them while `busy` have no effect.
- `ram_we` is high for exactly one cycle per write and is never high outside ACCESS.
- Reset values: state = IDLE, `last` = 1 (port 0 wins the first tie), `owner` = 0, and all latches are 0. As a result `ram_addr` = 0, `ram_data` = 0, `ram_we` = 0, `ack0` = `ack1` = 0, `rdata0` = `rdata1` = 0, `busy` = 0.
- Reset mid-transaction: the transaction is abandoned with no ack, and `ram_we` drops immediately (asynchronously). A write in ACCESS when reset asserts may or may not reach the RAM; requesters must reissue it.

## Timing
- Request seen in IDLE in cycle n:
  - ACCESS in cycle n+1.
  - The RAM captures addr/we/data at the end of n+1.
  - RESP, with ack and rdata valid, in cycle n+2.
- Latency: two cycles from the request cycle to the ack cycle. One transaction per 3 cycles at maximum throughput.
- The requester deasserts `req`, or presents its next transaction, in the cycle after the ack. A `req` still high in IDLE at that point is treated as a new transaction.
- Contention: with both requests held continuously, grants alternate 0, 1, 0, 1, …; each port completes one access every 6 cycles.
- Addresses use the full AW width with no wrap logic. 0xFFFF is a legal address.

## Structure
- Shared package `dram_arb_pkg` holds:
  - the state encoding: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  - the port IDs: PORT_CPU = 1'b0, PORT_DBG = 1'b1;
  - the AW/DW defaults.
- Sub-module `rr_arb2` is a combinational 2-way round-robin picker. Inputs: `req0`, `req1`, `last`. Outputs: `grant_valid`, `grant_id`. Everything else is in `dram_arbiter`.

## Test plan
- Reset, then port 0 writes 0xBEEF to 0x0010 → `ram_we` high for exactly one cycle (ACCESS); `ack0` two cycles after the request cycle. Then port 0 reads 0x0010 → `rdata0` = 0xBEEF with `ack0`.
- `req0` and `req1` raised in the same cycle right after reset → port 0 acks first, then port 1; `owner` goes 0 then 1; `ack1` never overlaps `ack0`.
- Both requests held for 12 cycles → acks alternate 0, 1, 0, 1, each port acking every 6 cycles, `busy` low only in the IDLE cycles.
- Port 1 writes 0x1234 to 0xFFFF, then port 0 reads 0xFFFF → `rdata0` = 0x1234; address 0x0000 is unaffected (no wrap).
- Port 1 changes `addr1` from 0x0020 to 0x0030 while `busy` → the access uses 0x0020.
- `reset` pulsed low during RESP of a port 0 read → no `ack0`, every output returns to 0 immediately, and the next grant on a tie goes to port 0.
